// File: rtl/l1_i_cache_ctrl.sv
// Tag/valid/LRU controller for a 2-way set-associative, read-only L1 instruction cache.
// Detects hits, stalls the fetch port on a miss, requests the block from L2 and directs the refill way.
module l1_i_cache_ctrl #(
    parameter int TNUM = 21,
    parameter int INUM = 26 - TNUM
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [TNUM-1:0] tag_C_L1,
    input  logic [INUM-1:0] index_C_L1,
    input  logic            read_C_L1,
    input  logic            flush,
    input  logic            ready_L2_L1,
    output logic            stall,
    output logic            refill,
    output logic            way,
    output logic            read_L1_L2,
    output logic [INUM-1:0] index_L1_L2,
    output logic [TNUM-1:0] tag_L1_L2
);
    localparam int SETS = 1 << INUM;

    typedef enum logic [1:0] {IDLE, MISS, REFILL} state_t;
    state_t state_reg, state_next;

    logic [TNUM-1:0] tag0_mem [SETS];
    logic [TNUM-1:0] tag1_mem [SETS];
    logic [SETS-1:0] valid0_reg;
    logic [SETS-1:0] valid1_reg;
    logic [SETS-1:0] lru_reg;

    logic [TNUM-1:0] req_tag_reg;
    logic [INUM-1:0] req_index_reg;
    logic            victim_reg;

    logic hit0, hit1, hit, victim_next;

    assign hit0 = valid0_reg[index_C_L1] && (tag0_mem[index_C_L1] == tag_C_L1);
    assign hit1 = valid1_reg[index_C_L1] && (tag1_mem[index_C_L1] == tag_C_L1);
    assign hit  = read_C_L1 && (hit0 || hit1);

    // Fill an empty way first (way0 before way1); only evict via LRU when the set is full.
    always_comb begin
        victim_next = lru_reg[index_C_L1];
        if (!valid0_reg[index_C_L1]) begin
            victim_next = 1'b0;
        end else if (!valid1_reg[index_C_L1]) begin
            victim_next = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        refill     = 1'b0;
        read_L1_L2 = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = read_C_L1 && !hit;
                if (read_C_L1 && !hit) begin
                    state_next = MISS;
                end
            end
            MISS: begin
                stall      = 1'b1;
                read_L1_L2 = 1'b1;
                if (ready_L2_L1) begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                stall      = 1'b1;
                refill     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything but reset, including a pending miss.
        if (flush) begin
            stall      = 1'b0;
            refill     = 1'b0;
            read_L1_L2 = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_reg     <= IDLE;
            valid0_reg    <= '0;
            valid1_reg    <= '0;
            lru_reg       <= '0;
            req_tag_reg   <= '0;
            req_index_reg <= '0;
            victim_reg    <= 1'b0;
        end else if (flush) begin
            state_reg  <= IDLE;
            valid0_reg <= '0;
            valid1_reg <= '0;
            lru_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (hit) begin
                        // lru points at the way that was not just used
                        lru_reg[index_C_L1] <= hit0;
                    end else if (read_C_L1) begin
                        req_tag_reg   <= tag_C_L1;
                        req_index_reg <= index_C_L1;
                        victim_reg    <= victim_next;
                    end
                end
                REFILL: begin
                    if (victim_reg) begin
                        valid1_reg[req_index_reg] <= 1'b1;
                    end else begin
                        valid0_reg[req_index_reg] <= 1'b1;
                    end
                    lru_reg[req_index_reg] <= ~victim_reg;
                end
                default: ;
            endcase
        end
    end

    // Tag arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!nrst && !flush && state_reg == REFILL) begin
            if (victim_reg) begin
                tag1_mem[req_index_reg] <= req_tag_reg;
            end else begin
                tag0_mem[req_index_reg] <= req_tag_reg;
            end
        end
    end

    assign way         = victim_reg;
    assign index_L1_L2 = req_index_reg;
    assign tag_L1_L2   = req_tag_reg;

endmodule

// File: tb/tb_l1_i_cache_ctrl.sv
// Randomized self-checking bench for l1_i_cache_ctrl against a per-set cache-state model.
module tb_l1_i_cache_ctrl;
    localparam int TNUM = 21;
    localparam int INUM = 5;
    localparam int SETS = 1 << INUM;

    logic            clk = 1'b0;
    logic            nrst = 1'b1;
    logic [TNUM-1:0] tag_C_L1 = '0;
    logic [INUM-1:0] index_C_L1 = '0;
    logic            read_C_L1 = 1'b0;
    logic            flush = 1'b0;
    logic            ready_L2_L1 = 1'b0;
    logic            stall, refill, way, read_L1_L2;
    logic [INUM-1:0] index_L1_L2;
    logic [TNUM-1:0] tag_L1_L2;

    int n_checks = 0;
    int n_fail = 0;

    // Model: what each set holds and which way is least recently used.
    logic [TNUM-1:0] m_tag [SETS][2];
    bit              m_valid [SETS][2];
    int              m_lru [SETS];

    logic [TNUM-1:0] way0_tags [15];
    logic [TNUM-1:0] way1_tags [15];

    l1_i_cache_ctrl #(.TNUM(TNUM), .INUM(INUM)) dut (
        .clk(clk), .nrst(nrst), .tag_C_L1(tag_C_L1), .index_C_L1(index_C_L1),
        .read_C_L1(read_C_L1), .flush(flush), .ready_L2_L1(ready_L2_L1),
        .stall(stall), .refill(refill), .way(way), .read_L1_L2(read_L1_L2),
        .index_L1_L2(index_L1_L2), .tag_L1_L2(tag_L1_L2)
    );

    always #5 clk = ~clk;

    function automatic int m_lookup(input logic [TNUM-1:0] t, input int ix);
        for (int w = 0; w < 2; w++)
            if (m_valid[ix][w] && m_tag[ix][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int ix);
        if (!m_valid[ix][0]) return 0;
        if (!m_valid[ix][1]) return 1;
        return m_lru[ix];
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s][0] = 0; m_valid[s][1] = 0; m_lru[s] = 0;
        end
    endtask

    // One fetch transaction; starts just after a rising edge and ends just after the edge that consumes the hit.
    task automatic do_fetch(input logic [TNUM-1:0] t, input logic [INUM-1:0] ix,
                            input int lat, input bit scramble);
        int hw, vic;
        logic [1:0] vic_b;
        tag_C_L1 = t; index_C_L1 = ix; read_C_L1 = 1'b1;
        @(negedge clk);
        hw = m_lookup(t, int'(ix));
        n_checks++;
        if (stall !== (hw < 0)) begin
            n_fail++; $display("FAIL idle_stall idx=%0d tag=%h got=%b want=%b", ix, t, stall, hw < 0);
        end
        if (hw >= 0) begin
            n_checks++;
            if (read_L1_L2 !== 1'b0 || refill !== 1'b0) begin
                n_fail++; $display("FAIL hit_no_l2 idx=%0d got read=%b refill=%b want 0 0", ix, read_L1_L2, refill);
            end
            m_lru[ix] = 1 - hw;
            $display("fetch idx=%0d tag=%h hit way=%0d", ix, t, hw);
            @(posedge clk); #1;
            return;
        end
        vic = m_victim(int'(ix));
        vic_b = 2'(vic);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (scramble) begin tag_C_L1 = TNUM'($urandom); index_C_L1 = INUM'($urandom); end
            if (c == lat) ready_L2_L1 = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({stall, read_L1_L2, refill, way, index_L1_L2, tag_L1_L2} !== {3'b110, vic_b[0], ix, t}) begin
                n_fail++;
                $display("FAIL miss_cycle c=%0d got st=%b rd=%b rf=%b way=%b idx=%0d tag=%h want 1 1 0 %0d %0d %h",
                         c, stall, read_L1_L2, refill, way, index_L1_L2, tag_L1_L2, vic, ix, t);
            end
        end
        @(posedge clk); #1;
        ready_L2_L1 = 1'b0; tag_C_L1 = t; index_C_L1 = ix;
        @(negedge clk);
        n_checks++;
        if ({stall, read_L1_L2, refill, way} !== {3'b101, vic_b[0]}) begin
            n_fail++;
            $display("FAIL refill_cycle got st=%b rd=%b rf=%b way=%b want 1 0 1 %0d", stall, read_L1_L2, refill, way, vic);
        end
        m_tag[ix][vic] = t; m_valid[ix][vic] = 1; m_lru[ix] = 1 - vic;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if ({stall, read_L1_L2, refill} !== 3'b000) begin
            n_fail++; $display("FAIL post_refill_hit got st=%b rd=%b rf=%b want 0 0 0", stall, read_L1_L2, refill);
        end
        @(posedge clk); #1;
        $display("fetch idx=%0d tag=%h miss lat=%0d refill way=%0d", ix, t, lat, vic);
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got st=%b rf=%b way=%b rd=%b idx=%0d tag=%h want all 0",
                               stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2);
        end
        @(posedge clk); #1;
        nrst = 1'b0;
        m_clear();
        $display("reset done");
    endtask

    task automatic test_cold_fill();
        for (int i = 0; i < 15; i++) begin
            way0_tags[i] = TNUM'($urandom);
            do_fetch(way0_tags[i], INUM'(i), 4, 0);
        end
    endtask

    task automatic test_second_way();
        for (int i = 0; i < 15; i++) begin
            way1_tags[i] = TNUM'($urandom);
            if (way1_tags[i] == way0_tags[i]) way1_tags[i] = ~way1_tags[i];
            do_fetch(way1_tags[i], INUM'(i), 1 + (i % 4), 0);
        end
    endtask

    task automatic test_hit_path();
        for (int i = 0; i < 10; i++) begin
            do_fetch(way0_tags[i], INUM'(i), 1, 0);
            do_fetch(way1_tags[i], INUM'(i), 1, 0);
        end
    endtask

    task automatic test_lru();
        logic [TNUM-1:0] t_new1, t_new2;
        t_new1 = way0_tags[3] ^ 21'h155555;
        t_new2 = way0_tags[3] ^ 21'h0AAAAA;
        do_fetch(way0_tags[3], 5'd3, 2, 0);
        do_fetch(t_new1, 5'd3, 2, 0);
        do_fetch(t_new1, 5'd3, 2, 0);
        do_fetch(t_new2, 5'd3, 2, 0);
        do_fetch(way0_tags[3], 5'd3, 2, 0);
    endtask

    task automatic test_long_latency();
        do_fetch(TNUM'($urandom), 5'd20, 11, 1);
        do_fetch(TNUM'($urandom), 5'd20, 11, 1);
    endtask

    task automatic test_reset_mid_miss();
        tag_C_L1 = 21'h1ABCD; index_C_L1 = 5'd22; read_C_L1 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        nrst = 1'b1; ready_L2_L1 = 1'b1;
        @(posedge clk); #1;
        ready_L2_L1 = 1'b0; read_C_L1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall, refill, way, read_L1_L2, index_L1_L2, tag_L1_L2} !== '0) begin
            n_fail++; $display("FAIL reset_mid_miss got st=%b rf=%b rd=%b idx=%0d tag=%h want all 0",
                               stall, refill, read_L1_L2, index_L1_L2, tag_L1_L2);
        end
        @(posedge clk); #1;
        nrst = 1'b0;
        m_clear();
        $display("reset mid-miss done");
        do_fetch(21'h1ABCD, 5'd22, 3, 0);
    endtask

    task automatic test_flush();
        tag_C_L1 = 21'h0F0F0; index_C_L1 = 5'd21; read_C_L1 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1; ready_L2_L1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall, read_L1_L2, refill} !== 3'b000) begin
            n_fail++; $display("FAIL flush_mid_miss got st=%b rd=%b rf=%b want 0 0 0", stall, read_L1_L2, refill);
        end
        @(posedge clk); #1;
        flush = 1'b0; ready_L2_L1 = 1'b0; read_C_L1 = 1'b0;
        m_clear();
        @(negedge clk);
        n_checks++;
        if ({stall, read_L1_L2, refill} !== 3'b000) begin
            n_fail++; $display("FAIL after_flush_idle got st=%b rd=%b rf=%b want 0 0 0", stall, read_L1_L2, refill);
        end
        @(posedge clk); #1;
        $display("flush mid-miss done");
        do_fetch(way0_tags[5], 5'd5, 2, 0);
        do_fetch(way1_tags[5], 5'd5, 2, 0);
        tag_C_L1 = way1_tags[5]; index_C_L1 = 5'd5; read_C_L1 = 1'b1; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_with_read got st=%b want 0", stall);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        m_clear();
        $display("flush with read done");
        do_fetch(way1_tags[5], 5'd5, 3, 0);
        do_fetch(way0_tags[6], 5'd6, 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                read_C_L1 = 1'b0; flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                m_clear();
                $display("flush");
            end
            do_fetch(TNUM'($urandom_range(1, 6)), INUM'($urandom_range(0, 3)), $urandom_range(1, 4), 0);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_second_way();
        test_hit_path();
        test_lru();
        test_long_latency();
        test_reset_mid_miss();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_i_cache_ctrl.md
Name: l1_i_cache_ctrl

Overview:
- Tag/valid/LRU controller for a 2-way set-associative, read-only L1 instruction cache with 64-byte blocks.
- Sits between the CPU fetch port and L2: it detects hits and misses, stalls the CPU on a miss, and requests the block from L2.
- When L2 returns the block, it tells the data array which way to refill.
- It holds no data itself and never writes back, because it serves instructions only.

Parameters:
- TNUM, default 21: tag width in bits (address[31 -: TNUM]).
- INUM, default 26-TNUM (=5): index width; number of sets = 2^INUM (address[6 +: INUM]).

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- nrst, input, 1: reset, synchronous and active-high (the name is kept from the codebase).
- tag_C_L1, input, TNUM: tag of the fetch address.
- index_C_L1, input, INUM: set index of the fetch address.
- read_C_L1, input, 1: fetch request; held high until stall is low.
- flush, input, 1: invalidate the entire cache.
- ready_L2_L1, input, 1: one-cycle pulse from L2 meaning the requested block is available.
- stall, output, 1: CPU must hold its request (combinational).
- refill, output, 1: one-cycle pulse telling the data array to write the L2 block.
- way, output, 1: target way of the refill (0 or 1).
- read_L1_L2, output, 1: block read request to L2.
- index_L1_L2, output, INUM: index of the block requested from L2.
- tag_L1_L2, output, TNUM: tag of the block requested from L2.

Behaviour:
- Storage per set: tag0, tag1, valid0, valid1, and one lru bit. lru names the way to evict next.
- Reset (nrst high at a clock edge):
  - Clear all valid and lru bits; state goes to IDLE.
  - Tags are don't-care.
  - Outputs stall, refill, read_L1_L2 and way are 0; index_L1_L2 and tag_L1_L2 are 0.
- Reset mid-miss aborts the miss with no tag write.
- Hit = read_C_L1 & ((valid0 & tag0==tag_C_L1) | (valid1 & tag1==tag_C_L1)) at index_C_L1, evaluated combinationally.
- FSM states: IDLE, MISS, REFILL.
- IDLE:
  - stall = read_C_L1 & ~hit.
  - On a hit there is zero stall cycles; at the clock edge lru[index] <= the way that did not hit.
  - On a miss: latch tag and index into the request registers and latch the victim way.
    - Victim choice: the first invalid way (way0 before way1); otherwise lru[index].
    - Go to MISS.
  - read_C_L1 low: stall=0 and no state change.
- MISS:
  - stall=1, read_L1_L2=1; index_L1_L2, tag_L1_L2 and way come from the latched registers.
  - Stay in MISS until ready_L2_L1=1, then go to REFILL.
  - ready_L2_L1 is ignored in every other state.
- REFILL (exactly one cycle):
  - refill=1, stall=1, way=victim, read_L1_L2=0.
  - At the clock edge: tag[victim] <= latched tag, valid[victim] <= 1, lru[index] <= ~victim. Return to IDLE.
  - The still-held request then hits in IDLE, so stall drops one cycle after the refill pulse.
- Miss-to-hit latency: miss detected (T0), MISS from T1 until the ready pulse, REFILL one cycle after the ready pulse, hit the cycle after.
- Address change while stalled: the fetch address must be held while stall=1. The latched request is used regardless of input changes.
- flush (priority below reset, above everything else):
  - At the clock edge: clear all valid and lru bits; state goes to IDLE; any pending miss is aborted with no tag write.
  - While flush=1: stall, refill and read_L1_L2 are forced to 0.
- Simultaneous read_C_L1 and flush: flush wins; the read is re-evaluated after flush is released (it will miss).
- Way outputs outside MISS/REFILL hold their last value; index_L1_L2 and tag_L1_L2 hold their last latched value.
- Both ways valid with the same tag cannot occur, because only misses allocate.

Test Plan:
- Cold fill:
  - Stimulus: after reset, read 15 addresses with index 0..14 (tags random); pulse ready_L2_L1 4 cycles after each miss.
  - Required: each request gives stall=1, read_L1_L2=1 with the matching index and tag, then refill=1 with way=0 for one cycle, then stall=0.
- Second-way fill:
  - Stimulus: read addresses whose index collides with filled sets but with new tags.
  - Required: refill with way=1; both ways then valid.
- Hit path:
  - Stimulus: re-read 10 way0 addresses and 10 way1 addresses.
  - Required: stall=0 in the same cycle, read_L1_L2 never asserted, lru flips to the other way each time.
- LRU replacement:
  - Stimulus: in a full set, read the way0 address, then a new tag with the same index.
  - Required: victim way=1 with refill. Repeat after touching way1: victim way=0. The replaced old tag then misses again.
- Long L2 latency:
  - Stimulus: hold ready_L2_L1 low for 10 cycles.
  - Required: stall and read_L1_L2 stay 1 with stable index and tag; no refill until the ready pulse.
- Flush:
  - Stimulus: assert flush mid-miss and after fills.
  - Required: stall, read_L1_L2 and refill drop to 0; after release, previously hitting addresses miss and refill into way0.
